// File: rtl/multi_letter_pattern_detector_pkg.sv
// Shared types and constants for the multi-letter pattern detector.
// The default word is E = {11,10} followed by C = {11,00}, packed LSB-first.
package multi_letter_pattern_pkg;

    typedef enum logic {
        TRACK   = 1'b0,
        MATCHED = 1'b1
    } state_t;

    localparam logic [7:0] EC_PATTERN = 8'h3B;

endpackage

// File: rtl/multi_letter_pattern_detector_if.sv
// Symbol stream, pattern control and result bundle for the pattern detector.
interface multi_letter_pattern_detector_if #(
    parameter int SYM_W           = 2,
    parameter int SYMS_PER_LETTER = 2,
    parameter int NUM_LETTERS     = 2,
    parameter int CNT_W           = 8
);
    localparam int PW = NUM_LETTERS * SYMS_PER_LETTER * SYM_W;

    logic [SYM_W-1:0]       sym_in;
    logic                   sym_valid;
    logic [PW-1:0]          pattern_in;
    logic                   pattern_load;
    logic                   clear;
    logic [NUM_LETTERS-1:0] letters_detected;
    logic                   match_pulse;
    logic [CNT_W-1:0]       match_count;

    modport master (
        output sym_in, sym_valid, pattern_in, pattern_load, clear,
        input  letters_detected, match_pulse, match_count
    );

    modport slave (
        input  sym_in, sym_valid, pattern_in, pattern_load, clear,
        output letters_detected, match_pulse, match_count
    );

endinterface

// File: rtl/multi_letter_pattern_detector_letter_symbol_select.sv
// Picks the expected symbol at (letter_idx, sym_idx) and symbol 0 of the current letter.
// idx_ok is low for index combinations outside the pattern so the caller can recover.
module letter_symbol_select #(
    parameter int SYM_W           = 2,
    parameter int SYMS_PER_LETTER = 2,
    parameter int NUM_LETTERS     = 2,
    parameter int LI_W            = 1,
    parameter int SI_W            = 1
) (
    input  logic [NUM_LETTERS*SYMS_PER_LETTER*SYM_W-1:0] pattern,
    input  logic [LI_W-1:0]                              letter_idx,
    input  logic [SI_W-1:0]                              sym_idx,
    output logic [SYM_W-1:0]                             exp_sym,
    output logic [SYM_W-1:0]                             first_sym,
    output logic                                         idx_ok
);

    always_comb begin
        exp_sym   = '0;
        first_sym = '0;
        idx_ok    = 1'b0;
        for (int j = 0; j < NUM_LETTERS; j++) begin
            if (letter_idx == LI_W'(j)) begin
                first_sym = pattern[j*SYMS_PER_LETTER*SYM_W +: SYM_W];
                for (int k = 0; k < SYMS_PER_LETTER; k++) begin
                    if (sym_idx == SI_W'(k)) begin
                        exp_sym = pattern[(j*SYMS_PER_LETTER+k)*SYM_W +: SYM_W];
                        idx_ok  = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_letter_pattern_detector.sv
// Programmable word detector: tracks letters of SYMS_PER_LETTER symbols each,
// reports per-letter progress, a match strobe and a saturating match count.
module multi_letter_pattern_detector
    import multi_letter_pattern_pkg::*;
#(
    parameter int SYM_W           = 2,
    parameter int SYMS_PER_LETTER = 2,
    parameter int NUM_LETTERS     = 2,
    parameter int CNT_W           = 8,
    parameter bit STICKY          = 1'b0,
    parameter logic [NUM_LETTERS*SYMS_PER_LETTER*SYM_W-1:0] PATTERN_RESET =
        (NUM_LETTERS*SYMS_PER_LETTER*SYM_W)'(EC_PATTERN)
) (
    input  logic clk,
    input  logic rst_n,
    multi_letter_pattern_detector_if.slave bus
);

    localparam int PW   = NUM_LETTERS * SYMS_PER_LETTER * SYM_W;
    localparam int LI_W = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
    localparam int SI_W = (SYMS_PER_LETTER > 1) ? $clog2(SYMS_PER_LETTER) : 1;
    localparam logic [LI_W-1:0] LI_LAST = LI_W'(NUM_LETTERS - 1);
    localparam logic [SI_W-1:0] SI_LAST = SI_W'(SYMS_PER_LETTER - 1);

    state_t                 state_q, state_d;
    logic [LI_W-1:0]        letter_idx_q, letter_idx_d;
    logic [SI_W-1:0]        sym_idx_q, sym_idx_d;
    logic [NUM_LETTERS-1:0] letters_q, letters_d;
    logic                   pulse_q, pulse_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PW-1:0]          pattern_q, pattern_d;
    logic [SYM_W-1:0]       exp_sym, first_sym;
    logic                   idx_ok;
    logic                   restart;

    letter_symbol_select #(
        .SYM_W           (SYM_W),
        .SYMS_PER_LETTER (SYMS_PER_LETTER),
        .NUM_LETTERS     (NUM_LETTERS),
        .LI_W            (LI_W),
        .SI_W            (SI_W)
    ) u_sel (
        .pattern    (pattern_q),
        .letter_idx (letter_idx_q),
        .sym_idx    (sym_idx_q),
        .exp_sym    (exp_sym),
        .first_sym  (first_sym),
        .idx_ok     (idx_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TRACK;
            letter_idx_q <= '0;
            sym_idx_q    <= '0;
            letters_q    <= '0;
            pulse_q      <= 1'b0;
            count_q      <= '0;
            pattern_q    <= PATTERN_RESET;
        end else begin
            state_q      <= state_d;
            letter_idx_q <= letter_idx_d;
            sym_idx_q    <= sym_idx_d;
            letters_q    <= letters_d;
            pulse_q      <= pulse_d;
            count_q      <= count_d;
            pattern_q    <= pattern_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        letter_idx_d = letter_idx_q;
        sym_idx_d    = sym_idx_q;
        letters_d    = letters_q;
        pulse_d      = 1'b0;
        count_d      = count_q;
        pattern_d    = pattern_q;
        restart      = 1'b0;

        if (bus.clear) begin
            restart = 1'b1;
            count_d = '0;
        end else if (bus.pattern_load) begin
            restart   = 1'b1;
            pattern_d = bus.pattern_in;
        end else begin
            case (state_q)
                TRACK: begin
                    if (!idx_ok) begin
                        restart = 1'b1;
                    end else if (bus.sym_valid) begin
                        if (bus.sym_in == exp_sym) begin
                            if (sym_idx_q != SI_LAST) begin
                                sym_idx_d = sym_idx_q + SI_W'(1);
                            end else if (letter_idx_q != LI_LAST) begin
                                for (int j = 0; j < NUM_LETTERS; j++)
                                    if (letter_idx_q == LI_W'(j)) letters_d[j] = 1'b1;
                                letter_idx_d = letter_idx_q + LI_W'(1);
                                sym_idx_d    = '0;
                            end else begin
                                letters_d = '1;
                                pulse_d   = 1'b1;
                                state_d   = MATCHED;
                                if (count_q != '1) count_d = count_q + CNT_W'(1);
                            end
                        end else if (sym_idx_q != '0) begin
                            // A miss may itself start a fresh attempt at the current letter
                            if (SYMS_PER_LETTER > 1 && bus.sym_in == first_sym)
                                sym_idx_d = SI_W'(1);
                            else
                                sym_idx_d = '0;
                        end
                    end
                end
                MATCHED: begin
                    if (!STICKY) restart = 1'b1;
                end
                default: restart = 1'b1;
            endcase
        end

        if (restart) begin
            state_d      = TRACK;
            letter_idx_d = '0;
            sym_idx_d    = '0;
            letters_d    = '0;
        end
    end

    assign bus.letters_detected = letters_q;
    assign bus.match_pulse      = pulse_q;
    assign bus.match_count      = count_q;

endmodule

// File: tb/tb_multi_letter_pattern_detector.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_multi_letter_pattern_detector;

    typedef struct {
        logic [1:0] letters;
        logic       pulse;
        logic [7:0] count;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_letter_pattern_detector_if bus_a ();
    multi_letter_pattern_detector_if bus_s ();

    multi_letter_pattern_detector #(.STICKY(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    multi_letter_pattern_detector #(.STICKY(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    exp_t q_a[$];
    exp_t q_s[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string who, input exp_t e,
                       input logic [1:0] l, input logic p, input logic [7:0] c);
        checks++;
        if (l !== e.letters || p !== e.pulse || c !== e.count) begin
            errors++;
            $display("FAIL %s/%s: got letters=%b pulse=%b count=%0d, want letters=%b pulse=%b count=%0d",
                     who, e.name, l, p, c, e.letters, e.pulse, e.count);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("sticky0", e, bus_a.letters_detected, bus_a.match_pulse, bus_a.match_count);
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            chk("sticky1", e, bus_s.letters_detected, bus_s.match_pulse, bus_s.match_count);
        end
    end

    function automatic exp_t mk(input logic [1:0] l, input logic p, input int c, input string nm);
        exp_t e;
        e.letters = l;
        e.pulse   = p;
        e.count   = 8'(c);
        e.name    = nm;
        return e;
    endfunction

    task automatic idle_all();
        bus_a.sym_valid = 1'b0; bus_a.pattern_load = 1'b0; bus_a.clear = 1'b0;
        bus_s.sym_valid = 1'b0; bus_s.pattern_load = 1'b0; bus_s.clear = 1'b0;
    endtask

    // One clock of stimulus to one DUT, expectation queued right after the edge.
    task automatic step(input bit s, input bit v, input logic [1:0] sym, input bit ld,
                        input logic [7:0] pat, input bit clr,
                        input logic [1:0] el, input bit ep, input int ec, input string nm);
        if (s) begin
            bus_s.sym_valid = v; bus_s.sym_in = sym; bus_s.pattern_load = ld;
            bus_s.pattern_in = pat; bus_s.clear = clr;
        end else begin
            bus_a.sym_valid = v; bus_a.sym_in = sym; bus_a.pattern_load = ld;
            bus_a.pattern_in = pat; bus_a.clear = clr;
        end
        @(posedge clk);
        #1;
        if (s) q_s.push_back(mk(el, ep, ec, nm));
        else   q_a.push_back(mk(el, ep, ec, nm));
        idle_all();
    endtask

    task automatic sa(input logic [1:0] sym, input logic [1:0] el, input bit ep, input int ec, input string nm);
        step(1'b0, 1'b1, sym, 1'b0, 8'h00, 1'b0, el, ep, ec, nm);
    endtask

    task automatic ia(input logic [1:0] el, input bit ep, input int ec, input string nm);
        step(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, el, ep, ec, nm);
    endtask

    task automatic ss(input logic [1:0] sym, input logic [1:0] el, input bit ep, input int ec, input string nm);
        step(1'b1, 1'b1, sym, 1'b0, 8'h00, 1'b0, el, ep, ec, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cp;
        bus_a.sym_in = '0; bus_a.pattern_in = '0;
        bus_s.sym_in = '0; bus_s.pattern_in = '0;
        idle_all();
        q_a.push_back(mk(2'b00, 1'b0, 0, "reset"));
        q_s.push_back(mk(2'b00, 1'b0, 0, "reset"));
        #12 rst_n = 1'b1;

        // E/C word on the restart-mode detector
        sa(2'b00, 2'b00, 0, 0, "ec_00a");
        sa(2'b00, 2'b00, 0, 0, "ec_00b");
        sa(2'b11, 2'b00, 0, 0, "ec_l0s0");
        sa(2'b10, 2'b01, 0, 0, "ec_l0done");
        sa(2'b00, 2'b01, 0, 0, "ec_l1miss_a");
        sa(2'b00, 2'b01, 0, 0, "ec_l1miss_b");
        sa(2'b11, 2'b01, 0, 0, "ec_l1s0");
        sa(2'b00, 2'b11, 1, 1, "ec_match");
        sa(2'b11, 2'b00, 0, 1, "matched_drop");
        sa(2'b10, 2'b00, 0, 1, "after_restart");

        // Overlap inside letter 0, with an idle hold
        sa(2'b11, 2'b00, 0, 1, "ov_11a");
        ia(2'b00, 0, 1, "ov_idle");
        sa(2'b11, 2'b00, 0, 1, "ov_11b");
        sa(2'b11, 2'b00, 0, 1, "ov_11c");
        sa(2'b10, 2'b01, 0, 1, "ov_l0done");

        // Mid-letter miss keeps letter progress and drops sym_idx
        sa(2'b11, 2'b01, 0, 1, "miss_11");
        ia(2'b01, 0, 1, "miss_idle_hold");
        sa(2'b01, 2'b01, 0, 1, "miss_01");
        sa(2'b00, 2'b01, 0, 1, "miss_idx0");
        sa(2'b11, 2'b01, 0, 1, "miss_11b");
        sa(2'b00, 2'b11, 1, 2, "miss_match");
        ia(2'b00, 0, 2, "miss_restart");

        // Load all-zero pattern with a symbol that must be dropped
        step(1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b0, 2'b00, 0, 2, "load_drop");
        sa(2'b00, 2'b00, 0, 2, "z_s0");
        sa(2'b00, 2'b01, 0, 2, "z_l0");
        sa(2'b00, 2'b01, 0, 2, "z_s2");
        sa(2'b00, 2'b11, 1, 3, "z_match");
        ia(2'b00, 0, 3, "z_restart");

        // Drive the counter into saturation
        for (int i = 0; i < 254; i++) begin
            cp = (3 + i > 255) ? 255 : 3 + i;
            c  = (4 + i > 255) ? 255 : 4 + i;
            sa(2'b00, 2'b00, 0, cp, "sat_s0");
            sa(2'b00, 2'b01, 0, cp, "sat_l0");
            sa(2'b00, 2'b01, 0, cp, "sat_s2");
            sa(2'b00, 2'b11, 1, c, "sat_match");
            ia(2'b00, 0, c, "sat_restart");
        end

        // Async reset between edges mid-word
        sa(2'b00, 2'b00, 0, 255, "rst_s0");
        sa(2'b00, 2'b01, 0, 255, "rst_l0");
        #5 rst_n = 1'b0;
        #1 chk("sticky0", mk(2'b00, 1'b0, 0, "async_reset"),
               bus_a.letters_detected, bus_a.match_pulse, bus_a.match_count);
        #1 rst_n = 1'b1;
        sa(2'b11, 2'b00, 0, 0, "rp_l0s0");
        sa(2'b10, 2'b01, 0, 0, "rp_l0done");
        sa(2'b11, 2'b01, 0, 0, "rp_l1s0");
        sa(2'b00, 2'b11, 1, 1, "rp_match");
        ia(2'b00, 0, 1, "rp_restart");

        // clear outranks pattern_load: pattern must stay E/C
        step(1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 2'b00, 0, 0, "clr_ld");
        sa(2'b00, 2'b00, 0, 0, "clr_00a");
        sa(2'b00, 2'b00, 0, 0, "clr_00b");
        sa(2'b11, 2'b00, 0, 0, "clr_11");
        sa(2'b10, 2'b01, 0, 0, "clr_l0done");

        // Sticky detector holds its result until clear
        ss(2'b11, 2'b00, 0, 0, "st_l0s0");
        ss(2'b10, 2'b01, 0, 0, "st_l0done");
        ss(2'b11, 2'b01, 0, 0, "st_l1s0");
        ss(2'b00, 2'b11, 1, 1, "st_match");
        for (int i = 0; i < 20; i++)
            ss(2'($urandom_range(3, 0)), 2'b11, 0, 1, "st_hold");
        step(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 2'b00, 0, 0, "st_clear");
        ss(2'b11, 2'b00, 0, 0, "st_after_s0");
        ss(2'b10, 2'b01, 0, 0, "st_after_l0");

        repeat (3) @(posedge clk);
        #6;
        if (q_a.size() != 0 || q_s.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_s.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_letter_pattern_detector.md
Name: multi_letter_pattern_detector

Overview:
- Parametrised sequence detector for streams of SYM_W-bit symbols.
- Recognises a programmable word of NUM_LETTERS letters. Each letter is a fixed run of SYMS_PER_LETTER symbols.
- Reports per-letter progress, a one-cycle match pulse and a saturating match counter.
- Successor to the fixed two-letter 2-bit detector: adds a symbol-valid qualifier, a runtime-loadable pattern, a sticky/restart mode, a clear input and a match count. Sits directly behind the symbol source in the recognition path.

Parameters:
- SYM_W, 2, bits per input symbol.
- SYMS_PER_LETTER, 2, symbols per letter (>=1).
- NUM_LETTERS, 2, letters per word (>=1).
- CNT_W, 8, match counter width.
- STICKY, 0, 1 = hold the matched result until clear; 0 = auto-restart after a match.
- PATTERN_RESET, 8'h3B, reset pattern, width PW = NUM_LETTERS*SYMS_PER_LETTER*SYM_W. The default encodes letter0 = 11,10 and letter1 = 11,00.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sym_in  in  SYM_W  input symbol.
- sym_valid  in  1  sym_in is consumed this cycle.
- pattern_in  in  PW  new pattern. Symbol k of letter j occupies bits [(j*SYMS_PER_LETTER+k)*SYM_W +: SYM_W].
- pattern_load  in  1  capture pattern_in and restart tracking.
- clear  in  1  restart tracking and zero match_count.
- letters_detected  out  NUM_LETTERS  bit j = letter j completed in the current word attempt.
- match_pulse  out  1  one-cycle strobe on word completion.
- match_count  out  CNT_W  saturating count of completed words.

Behaviour:
- Reset (async, rst_n=0):
  - pattern register = PATTERN_RESET.
  - letter_idx = 0, sym_idx = 0, state = TRACK.
  - letters_detected = 0, match_pulse = 0, match_count = 0.
- All outputs are registered. Response appears the cycle after the deciding symbol is sampled.
- Priority each cycle: clear > pattern_load > symbol processing.
  - clear: letter_idx = 0, sym_idx = 0, state = TRACK, letters_detected = 0, match_count = 0. Pattern register kept.
  - pattern_load: pattern register <= pattern_in and tracking restarts as for clear, but match_count is kept.
  - A symbol presented together with clear or pattern_load is dropped.
- sym_valid=0: state, indices and letters_detected hold. match_pulse = 0.
- State TRACK, with sym_valid=1, exp = pattern symbol (letter_idx, sym_idx):
  - Hit (sym_in == exp) with sym_idx < SYMS_PER_LETTER-1: sym_idx++.
  - Hit with sym_idx = SYMS_PER_LETTER-1 and letter_idx < NUM_LETTERS-1: letters_detected[letter_idx] <= 1, letter_idx++, sym_idx = 0.
  - Hit on the last symbol of the last letter: letters_detected <= all ones, match_pulse <= 1, match_count++ (holds at max, no wrap), state = MATCHED.
  - Miss with sym_idx = 0: stay.
  - Miss with sym_idx > 0: if sym_in equals symbol 0 of the current letter and SYMS_PER_LETTER > 1, sym_idx = 1; otherwise sym_idx = 0.
  - A miss never clears letters already detected. Only clear, pattern_load or a restart clears them.
- State MATCHED:
  - match_pulse is 0 from the second cycle onward.
  - STICKY=1: remain in MATCHED and ignore symbols until clear or pattern_load.
  - STICKY=0: exactly one cycle in MATCHED, then state = TRACK, letter_idx = 0, sym_idx = 0, letters_detected = 0. Any symbol presented during that cycle is dropped.
- Index widths: $clog2 of the range, minimum 1 bit. Indices never exceed their range. Illegal states recover to TRACK with index 0.
- Reset mid-word: immediate return to reset values. Pattern reverts to PATTERN_RESET.

Decomposition:
- Package multi_letter_pattern_pkg: state enum (TRACK, MATCHED) and the default PATTERN_RESET constant for the E/C word.
- One sub-module, letter_symbol_select: combinational mux returning the pattern symbol at (letter_idx, sym_idx) plus symbol 0 of the current letter.

Test Plan:
- Default params, reset, then valid symbols 00,00,11,10 -> letters_detected=01 one cycle after the 10. Then 00,00,11,00 -> letters_detected=11, match_pulse high for 1 cycle, match_count=1, letters_detected=00 two cycles after the final 00.
- Letter-0 overlap: symbols 11,11,11,10 -> letters_detected=01 after the 10, because repeated 11 keeps sym_idx=1.
- Miss mid-letter keeps progress: after letter0 detected, send 11,01 -> letters_detected stays 01 and sym_idx returns to 0. Then 11,00 -> match_pulse.
- STICKY=1: complete the word, then send 20 random valid symbols -> letters_detected stays 11, match_count stays 1. After clear -> all outputs 0.
- pattern_load with pattern_in=8'h00 (every symbol 00) asserted together with sym_valid -> that symbol is dropped. Four 00 symbols then give match_pulse. 255 further matches with CNT_W=8 -> match_count saturates at 255.
- rst_n asserted asynchronously between clock edges mid-word -> outputs 0 immediately. Pattern back to 8'h3B, verified by the E/C sequence matching again.
